// File: rtl/err_pkg.sv
// err_pkg: shared FSM state type and saturation helper for the IR error sequencer
package err_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} err_state_t;
  localparam int SAT_W = 64;
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v, input int err_w);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (err_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/err_compute_seq_if.sv
// err_compute_seq_if: sensor-frame handshake, channel select and error result bundle
interface err_compute_seq_if #(
  parameter int NUM_PAIRS = 4,
  parameter int DW        = 12,
  parameter int ERR_W     = 16
);
  localparam int SEL_W = ($clog2(2 * NUM_PAIRS) < 1) ? 1 : $clog2(2 * NUM_PAIRS);
  logic                    IR_vld;
  logic [DW-1:0]           ir_data;
  logic [SEL_W-1:0]        sel;
  logic signed [ERR_W-1:0] error;
  logic                    err_vld;
  logic                    busy;
  modport master (output IR_vld, ir_data, input sel, error, err_vld, busy);
  modport slave  (input IR_vld, ir_data, output sel, error, err_vld, busy);
endinterface

// File: rtl/err_accum.sv
// err_accum: signed shift-add accumulator for weighted right/left sensor differences
module err_accum #(
  parameter int DW    = 12,
  parameter int ACC_W = 17,
  parameter int SH_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sub,
  input  logic [SH_W-1:0]         shamt,
  input  logic [DW-1:0]           data,
  output logic signed [ACC_W-1:0] acc
);
  logic [ACC_W-1:0]        term;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  assign term  = ACC_W'(data) << shamt;
  assign acc_d = clr ? '0 : !en ? acc_q : sub ? acc_q - $signed(term) : acc_q + $signed(term);
  // accumulator register; clear wins over accumulate so a restart always begins from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
  assign acc = acc_q;
endmodule

// File: rtl/err_compute_seq.sv
// err_compute_seq: steps the IR channel select, accumulates weighted differences, emits saturated error
module err_compute_seq
  import err_pkg::*;
#(
  parameter int NUM_PAIRS = 4,
  parameter int DW        = 12,
  parameter int ERR_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  err_compute_seq_if.slave  bus
);
  localparam int ACC_W = DW + NUM_PAIRS + 1;
  localparam int SEL_W = ($clog2(2 * NUM_PAIRS) < 1) ? 1 : $clog2(2 * NUM_PAIRS);
  localparam int LAST  = 2 * NUM_PAIRS - 1;
  err_state_t              state_q;
  logic [SEL_W-1:0]        cnt_q;
  logic signed [ERR_W-1:0] error_q;
  logic                    err_vld_q;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_en;
  logic [SEL_W-1:0]        shamt;
  assign acc_en = state_q == ACCUM;
  assign shamt  = cnt_q >> 1;
  err_accum #(.DW(DW), .ACC_W(ACC_W), .SH_W(SEL_W)) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.IR_vld),
    .en    (acc_en),
    .sub   (cnt_q[0]),
    .shamt (shamt),
    .data  (bus.ir_data),
    .acc   (acc)
  );
  // sequencer: a new frame restarts the sweep from any state; DONE publishes the saturated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      error_q   <= '0;
      err_vld_q <= 1'b0;
    end else if (bus.IR_vld) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      err_vld_q <= 1'b0;
    end else begin
      err_vld_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == SEL_W'(LAST)) ? DONE : ACCUM;
        end
        DONE: begin
          error_q   <= ERR_W'(sat(SAT_W'(acc), ERR_W));
          err_vld_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.sel     = (state_q == ACCUM) ? cnt_q : '0;
  assign bus.busy    = state_q != IDLE;
  assign bus.error   = error_q;
  assign bus.err_vld = err_vld_q;
endmodule
